// File: rtl/rmt_repair_ram_pkg.sv
// Shared types and default sizing for the rename-map repair table.
package rmt_repair_ram_pkg;
  localparam int RMT_DEPTH     = 34;
  localparam int RMT_INDEX     = 6;
  localparam int RMT_WIDTH     = 7;
  localparam int RMT_N_WR      = 4;
  localparam int RMT_N_PACKETS = 8;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    REPAIR = 2'd1,
    DONE   = 2'd2
  } rmt_state_e;
endpackage

// File: rtl/rmt_repair_ram_wr_merge.sv
// Collapses N address/data write requests into per-entry write enables;
// on colliding addresses the highest-numbered request wins.
module rmt_wr_merge
  import rmt_repair_ram_pkg::*;
#(
  parameter int N     = RMT_N_WR,
  parameter int DEPTH = RMT_DEPTH,
  parameter int INDEX = RMT_INDEX,
  parameter int WIDTH = RMT_WIDTH
) (
  input  logic [N-1:0]                 en,
  input  logic [N-1:0][INDEX-1:0]      addr,
  input  logic [N-1:0][WIDTH-1:0]      data,
  output logic [DEPTH-1:0]             we,
  output logic [DEPTH-1:0][WIDTH-1:0]  wd
);

  // Ascending scan so later (higher) requests overwrite earlier ones;
  // addresses >= DEPTH never match an entry and are dropped here.
  always_comb begin
    we = '0;
    wd = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int i = 0; i < N; i++) begin
        if (en[i] && (32'(addr[i]) == e)) begin
          we[e] = 1'b1;
          wd[e] = data[i];
        end
      end
    end
  end

endmodule

// File: rtl/rmt_repair_ram.sv
// Rename map table with multi-lane dispatch writes and a beat-based repair
// sequence that locks dispatch out until the table is rebuilt.
module rmt_repair_ram
  import rmt_repair_ram_pkg::*;
#(
  parameter int DEPTH     = RMT_DEPTH,
  parameter int INDEX     = RMT_INDEX,
  parameter int WIDTH     = RMT_WIDTH,
  parameter int N_WR      = RMT_N_WR,
  parameter int N_PACKETS = RMT_N_PACKETS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_WR-1:0]                     laneActive_i,
  input  logic [2*N_WR-1:0][INDEX-1:0]        rdAddr_i,
  output logic [2*N_WR-1:0][WIDTH-1:0]        rdData_o,
  input  logic [N_WR-1:0]                     wrEn_i,
  input  logic [N_WR-1:0][INDEX-1:0]          wrAddr_i,
  input  logic [N_WR-1:0][WIDTH-1:0]          wrData_i,
  input  logic                                repairStart_i,
  input  logic                                repairValid_i,
  input  logic                                repairLast_i,
  input  logic [N_PACKETS-1:0]                repairPktValid_i,
  input  logic [N_PACKETS-1:0][INDEX-1:0]     repairAddr_i,
  input  logic [N_PACKETS-1:0][WIDTH-1:0]     repairData_i,
  output logic                                repairReady_o,
  output logic                                rmtReady_o,
  output logic                                dropErr_o
);

  rmt_state_e state_q, state_d;
  logic [WIDTH-1:0] ram [DEPTH];
  logic             drop_q;

  logic [N_WR-1:0]                lane_en;
  logic [N_PACKETS-1:0]           pkt_en;
  logic [DEPTH-1:0]               lane_we, pkt_we;
  logic [DEPTH-1:0][WIDTH-1:0]    lane_wd, pkt_wd;
  logic                           dispatch_req;

  assign rmtReady_o    = (state_q == NORMAL);
  assign repairReady_o = (state_q == REPAIR);
  assign dropErr_o     = drop_q;

  // Dispatch writes are discarded in the cycle a repair is launched.
  assign lane_en      = (rmtReady_o && !repairStart_i) ? (wrEn_i & laneActive_i) : '0;
  assign pkt_en       = (repairReady_o && repairValid_i) ? repairPktValid_i : '0;
  assign dispatch_req = |(wrEn_i & laneActive_i);

  rmt_wr_merge #(.N(N_WR), .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH)) u_lane_merge (
    .en   (lane_en),
    .addr (wrAddr_i),
    .data (wrData_i),
    .we   (lane_we),
    .wd   (lane_wd)
  );

  rmt_wr_merge #(.N(N_PACKETS), .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH)) u_pkt_merge (
    .en   (pkt_en),
    .addr (repairAddr_i),
    .data (repairData_i),
    .we   (pkt_we),
    .wd   (pkt_wd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:  if (repairStart_i) state_d = REPAIR;
      REPAIR:  if (repairValid_i && repairLast_i) state_d = DONE;
      DONE:    state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NORMAL;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!rmtReady_o && dispatch_req) drop_q <= 1'b1;
    end
  end

  // Reset restores the identity mapping: architectural reg i -> physical tag i.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < DEPTH; e++) ram[e] <= WIDTH'(e);
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (pkt_we[e])       ram[e] <= pkt_wd[e];
        else if (lane_we[e]) ram[e] <= lane_wd[e];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2*N_WR; k++) begin
      rdData_o[k] = '0;
      if (32'(rdAddr_i[k]) < DEPTH) rdData_o[k] = ram[rdAddr_i[k]];
    end
  end

endmodule

// File: tb/tb_rmt_repair_ram.sv
// Self-checking bench for rmt_repair_ram: directed scenarios plus random traffic
// compared against a behavioural model of the map table and repair sequence.
`timescale 1ns/1ps
module tb_rmt_repair_ram;
  localparam int DEPTH     = 34;
  localparam int INDEX     = 6;
  localparam int WIDTH     = 7;
  localparam int N_WR      = 4;
  localparam int N_PACKETS = 8;
  localparam int N_RD      = 2*N_WR;

  logic                             clk = 1'b0;
  logic                             reset;
  logic [N_WR-1:0]                  laneActive;
  logic [N_RD-1:0][INDEX-1:0]       rdAddr;
  logic [N_RD-1:0][WIDTH-1:0]       rdData;
  logic [N_WR-1:0]                  wrEn;
  logic [N_WR-1:0][INDEX-1:0]       wrAddr;
  logic [N_WR-1:0][WIDTH-1:0]       wrData;
  logic                             repairStart, repairValid, repairLast;
  logic [N_PACKETS-1:0]             pktValid;
  logic [N_PACKETS-1:0][INDEX-1:0]  pktAddr;
  logic [N_PACKETS-1:0][WIDTH-1:0]  pktData;
  logic                             repairReady, rmtReady, dropErr;

  always #5 clk = ~clk;

  rmt_repair_ram #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .N_WR(N_WR), .N_PACKETS(N_PACKETS)) dut (
    .clk              (clk),
    .reset            (reset),
    .laneActive_i     (laneActive),
    .rdAddr_i         (rdAddr),
    .rdData_o         (rdData),
    .wrEn_i           (wrEn),
    .wrAddr_i         (wrAddr),
    .wrData_i         (wrData),
    .repairStart_i    (repairStart),
    .repairValid_i    (repairValid),
    .repairLast_i     (repairLast),
    .repairPktValid_i (pktValid),
    .repairAddr_i     (pktAddr),
    .repairData_i     (pktData),
    .repairReady_o    (repairReady),
    .rmtReady_o       (rmtReady),
    .dropErr_o        (dropErr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: table contents, phase (0 normal, 1 repairing, 2 draining), sticky drop.
  int mdl[DEPTH];
  int phase;
  bit mdrop;
  logic [WIDTH-1:0] got[DEPTH];

  task automatic idle();
    laneActive = '1; wrEn = '0; wrAddr = '0; wrData = '0;
    repairStart = 1'b0; repairValid = 1'b0; repairLast = 1'b0;
    pktValid = '0; pktAddr = '0; pktData = '0; rdAddr = '0;
  endtask

  task automatic model_reset();
    for (int e = 0; e < DEPTH; e++) mdl[e] = e % (1 << WIDTH);
    phase = 0;
    mdrop = 1'b0;
  endtask

  task automatic model_step();
    bit req;
    req = 1'b0;
    for (int i = 0; i < N_WR; i++) if (wrEn[i] && laneActive[i]) req = 1'b1;
    if (phase == 0) begin
      if (repairStart) phase = 1;
      else
        for (int i = 0; i < N_WR; i++)
          if (wrEn[i] && laneActive[i] && int'(wrAddr[i]) < DEPTH) mdl[int'(wrAddr[i])] = int'(wrData[i]);
    end else if (phase == 1) begin
      if (req) mdrop = 1'b1;
      if (repairValid) begin
        for (int j = 0; j < N_PACKETS; j++)
          if (pktValid[j] && int'(pktAddr[j]) < DEPTH) mdl[int'(pktAddr[j])] = int'(pktData[j]);
        if (repairLast) phase = 2;
      end
    end else begin
      if (req) mdrop = 1'b1;
      phase = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all();
    for (int base = 0; base < DEPTH; base += N_RD) begin
      for (int k = 0; k < N_RD; k++) rdAddr[k] = INDEX'(base + k);
      #1;
      for (int k = 0; k < N_RD; k++) if (base + k < DEPTH) got[base + k] = rdData[k];
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (rmtReady !== 1'b1) begin n_fail++; $display("FAIL reset_rmtReady: got %b expected 1", rmtReady); end
    n_checks++; if (repairReady !== 1'b0) begin n_fail++; $display("FAIL reset_repairReady: got %b expected 0", repairReady); end
    n_checks++; if (dropErr !== 1'b0) begin n_fail++; $display("FAIL reset_dropErr: got %b expected 0", dropErr); end
    reset = 1'b1;
    for (int k = 0; k < N_RD; k++) rdAddr[k] = INDEX'(k);
    #1;
    for (int k = 0; k < N_RD; k++) begin
      n_checks++;
      if (rdData[k] !== WIDTH'(k)) begin n_fail++; $display("FAIL reset_read port %0d: got %0d expected %0d", k, rdData[k], k); end
    end
    n_checks++; if (rmtReady !== 1'b1) begin n_fail++; $display("FAIL post_reset_rmtReady: got %b expected 1", rmtReady); end
    @(posedge clk); #1;
  endtask

  task automatic test_lane_priority();
    idle();
    wrEn[0] = 1'b1; wrAddr[0] = 6'd5; wrData[0] = 7'd20;
    wrEn[3] = 1'b1; wrAddr[3] = 6'd5; wrData[3] = 7'd21;
    rdAddr[0] = 6'd5;
    #1;
    n_checks++; if (rdData[0] !== 7'd5) begin n_fail++; $display("FAIL same_cycle_read: got %0d expected 5", rdData[0]); end
    tick();
    idle(); rdAddr[0] = 6'd5; #1;
    n_checks++; if (rdData[0] !== 7'd21) begin n_fail++; $display("FAIL lane_priority: got %0d expected 21", rdData[0]); end
  endtask

  task automatic test_repair();
    idle(); repairStart = 1'b1; tick();
    idle();
    n_checks++; if (repairReady !== 1'b1 || rmtReady !== 1'b0) begin n_fail++; $display("FAIL enter_repair: got ready=%b rmt=%b expected 1 0", repairReady, rmtReady); end
    repairValid = 1'b1; pktValid = 8'b0000_0011;
    pktAddr[0] = 6'd2; pktData[0] = 7'd40; pktAddr[1] = 6'd2; pktData[1] = 7'd41;
    tick();
    idle(); repairValid = 1'b1; repairLast = 1'b1;
    pktValid[0] = 1'b1; pktAddr[0] = 6'd9; pktData[0] = 7'd50;
    tick();
    idle();
    n_checks++; if (rmtReady !== 1'b0 || repairReady !== 1'b0) begin n_fail++; $display("FAIL done_cycle: got rmt=%b ready=%b expected 0 0", rmtReady, repairReady); end
    tick();
    n_checks++; if (rmtReady !== 1'b1) begin n_fail++; $display("FAIL rmt_ready_after_2: got %b expected 1", rmtReady); end
    read_all();
    n_checks++; if (got[2] !== 7'd41) begin n_fail++; $display("FAIL repair_priority: got %0d expected 41", got[2]); end
    n_checks++; if (got[9] !== 7'd50) begin n_fail++; $display("FAIL repair_last_beat: got %0d expected 50", got[9]); end
    for (int e = 0; e < DEPTH; e++) begin
      n_checks++; if (got[e] !== WIDTH'(mdl[e])) begin n_fail++; $display("FAIL repair_table[%0d]: got %0d expected %0d", e, got[e], mdl[e]); end
    end
  endtask

  task automatic test_drop();
    idle(); repairStart = 1'b1; tick();
    idle(); wrEn[0] = 1'b1; wrAddr[0] = 6'd4; wrData[0] = 7'd99; tick();
    idle();
    n_checks++; if (dropErr !== 1'b1) begin n_fail++; $display("FAIL drop_set: got %b expected 1", dropErr); end
    repairValid = 1'b1; repairLast = 1'b1; tick();
    idle(); tick();
    n_checks++; if (rmtReady !== 1'b1) begin n_fail++; $display("FAIL empty_last_beat: got %b expected 1", rmtReady); end
    n_checks++; if (dropErr !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %b expected 1", dropErr); end
    read_all();
    n_checks++; if (got[4] !== WIDTH'(mdl[4])) begin n_fail++; $display("FAIL drop_no_write: got %0d expected %0d", got[4], mdl[4]); end
  endtask

  task automatic test_reset_mid_repair();
    idle(); repairStart = 1'b1; tick();
    idle(); repairValid = 1'b1; pktValid = 8'b0000_0011;
    pktAddr[0] = 6'd3; pktData[0] = 7'd77; pktAddr[1] = 6'd10; pktData[1] = 7'd88;
    tick();
    idle(); repairValid = 1'b1; pktValid[0] = 1'b1; pktAddr[0] = 6'd11; pktData[0] = 7'd99;
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (rmtReady !== 1'b1 || repairReady !== 1'b0) begin n_fail++; $display("FAIL async_abort: got rmt=%b ready=%b expected 1 0", rmtReady, repairReady); end
    @(posedge clk); #1;
    idle(); reset = 1'b1; #1;
    read_all();
    for (int e = 0; e < DEPTH; e++) begin
      n_checks++; if (got[e] !== WIDTH'(mdl[e])) begin n_fail++; $display("FAIL reset_identity[%0d]: got %0d expected %0d", e, got[e], mdl[e]); end
    end
    n_checks++; if (dropErr !== 1'b0) begin n_fail++; $display("FAIL reset_clears_drop: got %b expected 0", dropErr); end
    n_checks++; if (rmtReady !== 1'b1) begin n_fail++; $display("FAIL reset_state_normal: got %b expected 1", rmtReady); end
  endtask

  task automatic test_out_of_range();
    idle(); wrEn[1] = 1'b1; wrAddr[1] = 6'd40; wrData[1] = 7'd33; rdAddr[0] = 6'd40; #1;
    n_checks++; if (rdData[0] !== 7'd0) begin n_fail++; $display("FAIL oor_read: got %0d expected 0", rdData[0]); end
    tick();
    idle(); repairValid = 1'b1; pktValid[0] = 1'b1; pktAddr[0] = 6'd6; pktData[0] = 7'd60; tick();
    idle(); repairStart = 1'b1; tick();
    idle(); repairValid = 1'b1; repairLast = 1'b1; pktValid[2] = 1'b1; pktAddr[2] = 6'd40; pktData[2] = 7'd44; tick();
    idle(); tick();
    read_all();
    for (int e = 0; e < DEPTH; e++) begin
      n_checks++; if (got[e] !== WIDTH'(mdl[e])) begin n_fail++; $display("FAIL oor_table[%0d]: got %0d expected %0d", e, got[e], mdl[e]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      laneActive = N_WR'($urandom);
      wrEn = N_WR'($urandom);
      for (int i = 0; i < N_WR; i++) begin
        wrAddr[i] = INDEX'($urandom_range(0, 39));
        wrData[i] = WIDTH'($urandom);
      end
      repairStart = ($urandom_range(0, 7) == 0);
      repairValid = 1'($urandom_range(0, 1));
      repairLast  = ($urandom_range(0, 3) == 0);
      pktValid = N_PACKETS'($urandom);
      for (int j = 0; j < N_PACKETS; j++) begin
        pktAddr[j] = INDEX'($urandom_range(0, 39));
        pktData[j] = WIDTH'($urandom);
      end
      for (int k = 0; k < N_RD; k++) rdAddr[k] = INDEX'($urandom);
      #1;
      for (int k = 0; k < N_RD; k++) begin
        n_checks++;
        if (int'(rdAddr[k]) < DEPTH) begin
          if (rdData[k] !== WIDTH'(mdl[int'(rdAddr[k])])) begin n_fail++; $display("FAIL rand_read cyc %0d port %0d: got %0d expected %0d", n, k, rdData[k], mdl[int'(rdAddr[k])]); end
        end else if (rdData[k] !== '0) begin
          n_fail++; $display("FAIL rand_read_oor cyc %0d port %0d: got %0d expected 0", n, k, rdData[k]);
        end
      end
      n_checks++; if (rmtReady !== (phase == 0)) begin n_fail++; $display("FAIL rand_rmtReady cyc %0d: got %b expected %b", n, rmtReady, phase == 0); end
      n_checks++; if (repairReady !== (phase == 1)) begin n_fail++; $display("FAIL rand_repairReady cyc %0d: got %b expected %b", n, repairReady, phase == 1); end
      n_checks++; if (dropErr !== mdrop) begin n_fail++; $display("FAIL rand_dropErr cyc %0d: got %b expected %b", n, dropErr, mdrop); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_lane_priority();
    test_repair();
    test_drop();
    test_reset_mid_repair();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
